// File: rtl/struct_array_streamer.sv
// struct_array_streamer
//   Loads a packed array of N records {a,b,c} through a valid/ready handshake,
//   then streams a window of records (start index + count, wrapping modulo N)
//   out one record per output handshake.
//
// Optional feature macro: STRUCT_ARRAY_STREAMER_REVERSE_EN
//   When defined, adds the in_reverse input. A 1 captured at load makes the
//   window walk downwards, (index-1) mod N.
//
// Ports:
//   clk        - clock, all logic on rising edge
//   rst_n      - synchronous active-low reset
//   in_data    - packed records, record i at [i*REC_W +: REC_W], {a,b,c} MSB->LSB
//   in_first   - index of first record to emit (values >= N reduced by N)
//   in_count   - number of records to emit (0 or > N means N)
//   in_valid   - load request
//   in_reverse - (optional) walk the window downwards
//   in_ready   - a load can be accepted this cycle
//   out_a/b/c  - fields of the current record
//   out_index  - array index of the current record
//   out_last   - current record is the last of the window
//   out_valid  - out_* are valid
//   out_ready  - consumer accepts the current record
module struct_array_streamer #(
    parameter int N   = 8,
    parameter int A_W = 1,
    parameter int B_W = 4,
    parameter int C_W = 2,
    localparam int REC_W = A_W + B_W + C_W,
    localparam int IDX_W = $clog2(N),
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*REC_W-1:0]   in_data,
    input  logic [IDX_W-1:0]     in_first,
    input  logic [CNT_W-1:0]     in_count,
    input  logic                 in_valid,
`ifdef STRUCT_ARRAY_STREAMER_REVERSE_EN
    input  logic                 in_reverse,
`endif
    output logic                 in_ready,
    output logic [A_W-1:0]       out_a,
    output logic [B_W-1:0]       out_b,
    output logic [C_W-1:0]       out_c,
    output logic [IDX_W-1:0]     out_index,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t               state;
    logic [N*REC_W-1:0]   hold;
    logic [CNT_W-1:0]     remaining;
    logic                 reverse;

    logic [REC_W-1:0]     in_recs   [N];
    logic [REC_W-1:0]     hold_recs [N];

    logic                 load;
    logic                 fire;
    logic [IDX_W-1:0]     first_n;
    logic [CNT_W-1:0]     count_n;
    logic [IDX_W-1:0]     idx_next;
    logic [REC_W-1:0]     next_rec;

    for (genvar g = 0; g < N; g++) begin : g_rec
        assign in_recs[g]   = in_data[g*REC_W +: REC_W];
        assign hold_recs[g] = hold[g*REC_W +: REC_W];
    end

    assign fire     = out_valid && out_ready;
    assign in_ready = (state == IDLE) || (fire && out_last);
    assign load     = in_valid && in_ready;

    always_comb begin
        // Compare one bit wider so N == 2**IDX_W does not truncate to 0.
        first_n = in_first;
        if ({1'b0, in_first} >= (IDX_W + 1)'(N)) begin
            first_n = IDX_W'({1'b0, in_first} - (IDX_W + 1)'(N));
        end

        count_n = in_count;
        if ((in_count == '0) || (in_count > CNT_W'(N))) begin
            count_n = CNT_W'(N);
        end

        // Explicit wrap keeps non-power-of-two N correct.
        if (reverse) begin
            idx_next = (out_index == '0) ? IDX_W'(N - 1) : out_index - 1'b1;
        end else begin
            idx_next = (out_index == IDX_W'(N - 1)) ? '0 : out_index + 1'b1;
        end

        next_rec = load ? in_recs[first_n] : hold_recs[idx_next];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold      <= '0;
            remaining <= '0;
            reverse   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_index <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
        end else if (load) begin
            // Load wins over a coincident last-record fire: no bubble.
            state     <= STREAM;
            hold      <= in_data;
            remaining <= count_n;
`ifdef STRUCT_ARRAY_STREAMER_REVERSE_EN
            reverse   <= in_reverse;
`else
            reverse   <= 1'b0;
`endif
            out_valid <= 1'b1;
            out_last  <= (count_n == CNT_W'(1));
            out_index <= first_n;
            out_a     <= next_rec[REC_W-1 -: A_W];
            out_b     <= next_rec[C_W +: B_W];
            out_c     <= next_rec[C_W-1:0];
        end else if (fire) begin
            if (out_last) begin
                state     <= IDLE;
                remaining <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                remaining <= remaining - 1'b1;
                out_last  <= (remaining == CNT_W'(2));
                out_index <= idx_next;
                out_a     <= next_rec[REC_W-1 -: A_W];
                out_b     <= next_rec[C_W +: B_W];
                out_c     <= next_rec[C_W-1:0];
            end
        end
    end

endmodule

// File: doc/struct_array_streamer.md
Name: struct_array_streamer

Overview:
- Parametrised, sequential successor to the combinational packed-struct-array unpacker.
- Accepts a packed array of N records {a,b,c} through a valid/ready load handshake, then streams a window of records out one per handshake.
- The window is a start index plus a count, with modulo-N wrap-around.
- Sits between a wide register/bus source and narrow per-record consumers in the core test designs.

Parameters:
- N, 8, number of records in the packed array (N >= 2, need not be a power of two)
- A_W, 1, width of field a
- B_W, 4, width of field b
- C_W, 2, width of field c
- Derived, not overridable: REC_W = A_W+B_W+C_W; IDX_W = $clog2(N); CNT_W = $clog2(N+1)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- in_data  input  N*REC_W  packed array; record i at bits [i*REC_W +: REC_W]; within a record a is MSBs, then b, then c in LSBs
- in_first  input  IDX_W  index of first record to emit
- in_count  input  CNT_W  number of records to emit
- in_valid  input  1  load request
- in_ready  output  1  block can accept a load this cycle
- out_a  output  A_W  field a of current record
- out_b  output  B_W  field b of current record
- out_c  output  C_W  field c of current record
- out_index  output  IDX_W  array index of current record
- out_last  output  1  current record is the final one of the window
- out_valid  output  1  out_* fields valid
- out_ready  input  1  consumer accepts the current record

Behaviour:
- One clock, clk. Synchronous active-low reset rst_n, sampled only on the rising clk edge.
- Reset values: out_valid=0, out_a/out_b/out_c/out_index=0, out_last=0, internal state=IDLE, remaining=0. in_ready=1 from the first cycle after reset.
- States:
  - IDLE: out_valid=0, in_ready=1.
  - STREAM: out_valid=1.
- Load fires when in_valid && in_ready.
  - Captures in_data into the holding register.
  - Captures first index f and effective count k.
  - Next cycle: STREAM, out_valid=1, record f presented (latency 1 cycle).
- Index normalisation:
  - in_first >= N is reduced to in_first-N.
  - in_count == 0 is treated as N.
  - in_count > N is clamped to N.
- Output fire when out_valid && out_ready: index advances to (index+1) mod N on the next cycle.
  - Wrap from N-1 to 0 is explicit and correct for non-power-of-two N.
  - remaining decrements by 1.
- out_last=1 exactly while remaining==1. Fire with out_last: to IDLE unless a load fires in the same cycle.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last), combinational from state and out_ready.
  - A load coincident with the last-record fire gives back-to-back windows with no bubble.
  - The new window's first record is presented next cycle.
- Backpressure: while out_valid && !out_ready, all out_* hold stable, and in_data changes are ignored.
- out_* are registered; no combinational path from in_data to out_*.
- Reset asserted mid-stream: next cycle returns to reset values. The partial window is discarded and nothing further is emitted from it.

Optional Feature:
- Macro: STRUCT_ARRAY_STREAMER_REVERSE_EN.
- Defined:
  - Adds input port in_reverse (1 bit), captured at load.
  - When captured 1, the index steps to (index-1) mod N, wrapping 0 -> N-1.
  - All other rules are unchanged.
- Undefined: port absent; the index always ascends.

Test Plan:
All scenarios use default parameters and in_data = 56'b01111011011011101111100111110111001010001011100110101000.
1. Full window: first=0, count=0, out_ready=1 -> 8 records, one per cycle, starting the cycle after load:
   - (a,b,c) in order: 0/1010/00, 1/1100/11, 0/1000/10, 0/1110/01, 0/0111/11, 1/0111/11, 1/0110/11, 0/1111/01
   - out_last only on index 7.
2. Wrap: first=6, count=3 -> indices 6, 7, 0; values 1/0110/11, 0/1111/01, 0/1010/00; out_last on index 0; then out_valid=0.
3. Backpressure: first=3, count=2, out_ready low for 4 cycles -> out_index=3, 0/1110/01 held stable for all 4 cycles. Then index 4 (0/0111/11) is emitted with out_last.
4. Back-to-back: second load (first=5, count=1) held valid during the last fire of a count=1 window at index 2 -> in_ready=1 in that cycle, no gap, index 5 (1/0111/11) presented the next cycle.
5. Reset mid-stream: rst_n=0 for one cycle after the 2nd record of a full window -> out_valid=0, out_index=0 next cycle, in_ready=1; no residual records.
6. Reverse (REVERSE_EN defined): first=1, count=3, in_reverse=1 -> indices 1, 0, 7; values 1/1100/11, 0/1010/00, 0/1111/01.
